// File: rtl/fc8_bus_mem.sv
// rtl/fc8_bus_mem.sv - fc8 bus memory responder with read pipeline, backdoor preload, access counters
// Optional write-protected window enabled by defining FC8_MEM_WP_EN.
module fc8_bus_mem #(
   parameter int          ADDR_W   = 16,
   parameter int          DATA_W   = 8,
   parameter int          RD_LAT   = 1,
   parameter int          CNT_W    = 16,
   parameter logic [15:0] WP_BASE  = 16'hF000,
   parameter logic [15:0] WP_LIMIT = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       mem_addr_in,
   input  logic [DATA_W-1:0] mem_wdata_in,
   input  logic              mem_rd_en,
   input  logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_rdata_out,
   output logic              rd_valid,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [DATA_W-1:0] bd_data,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wr_count,
   output logic              wp_err,
   output logic [ADDR_W-1:0] wp_err_addr
);

   localparam int DEPTH = 2 ** ADDR_W;

`ifdef FC8_MEM_WP_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   // Window bounds widened by one bit so the compare is never against an all-ones constant.
   localparam logic [ADDR_W:0] WP_LO_X = {1'b0, WP_BASE[ADDR_W-1:0]};
   localparam logic [ADDR_W:0] WP_HI_X = {1'b0, WP_LIMIT[ADDR_W-1:0]};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   addr_x;
   logic              wp_hit;
   logic              wr_commit;

   logic              pipe_v [RD_LAT];
   logic [DATA_W-1:0] pipe_d [RD_LAT];

   assign addr      = mem_addr_in[ADDR_W-1:0];
   assign addr_x    = {1'b0, addr};
   assign wp_hit    = WP_ON && mem_wr_en && (addr_x >= WP_LO_X) && (addr_x <= WP_HI_X);
   assign wr_commit = mem_wr_en && !wp_hit;

   // Array is never reset; the bus write is ordered last so it wins a same-address backdoor write.
   always_ff @(posedge clk) begin
      if (bd_we)
         mem[bd_addr] <= bd_data;
      if (wr_commit)
         mem[addr] <= mem_wdata_in;
   end

   // Data stages only load behind a valid, so the last stage holds the most recent read result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < RD_LAT; k++) begin
            pipe_v[k] <= 1'b0;
            pipe_d[k] <= '0;
         end
      end else begin
         pipe_v[0] <= mem_rd_en;
         if (mem_rd_en)
            pipe_d[0] <= mem[addr];
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            if (pipe_v[k-1])
               pipe_d[k] <= pipe_d[k-1];
         end
      end
   end

   assign rd_valid      = pipe_v[RD_LAT-1];
   assign mem_rdata_out = pipe_d[RD_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (mem_rd_en && (rd_count != {CNT_W{1'b1}}))
            rd_count <= rd_count + 1'b1;
         if (wr_commit && (wr_count != {CNT_W{1'b1}}))
            wr_count <= wr_count + 1'b1;
      end
   end

`ifdef FC8_MEM_WP_EN
   logic              wp_err_q;
   logic [ADDR_W-1:0] wp_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_err_q  <= 1'b0;
         wp_addr_q <= '0;
      end else begin
         wp_err_q <= wp_hit;
         if (wp_hit)
            wp_addr_q <= addr;
      end
   end

   assign wp_err      = wp_err_q;
   assign wp_err_addr = wp_addr_q;
`else
   assign wp_err      = 1'b0;
   assign wp_err_addr = '0;
`endif

endmodule

// File: tb/tb_fc8_bus_mem.sv
// tb/tb_fc8_bus_mem.sv - directed self-checking bench for fc8_bus_mem (RD_LAT 1/3/2, CNT_W 4)
module tb_fc8_bus_mem;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        rd_en;
   logic        wr_en;
   logic        bd_we;
   logic [15:0] bd_addr;
   logic [7:0]  bd_data;

   logic [7:0]  rdata_a, rdata_b, rdata_c;
   logic        vld_a, vld_b, vld_c;
   logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
   logic [3:0]  rdc_c, wrc_c;
   logic        wpe_a, wpe_b, wpe_c;
   logic [15:0] wpa_a, wpa_b, wpa_c;

   int n_tests = 0;
   int n_fail  = 0;

   fc8_bus_mem #(.RD_LAT(1)) u_a (
      .clk(clk), .rst_n(rst_n), .mem_addr_in(addr), .mem_wdata_in(wdata),
      .mem_rd_en(rd_en), .mem_wr_en(wr_en), .mem_rdata_out(rdata_a), .rd_valid(vld_a),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
      .rd_count(rdc_a), .wr_count(wrc_a), .wp_err(wpe_a), .wp_err_addr(wpa_a));

   fc8_bus_mem #(.RD_LAT(3)) u_b (
      .clk(clk), .rst_n(rst_n), .mem_addr_in(addr), .mem_wdata_in(wdata),
      .mem_rd_en(rd_en), .mem_wr_en(wr_en), .mem_rdata_out(rdata_b), .rd_valid(vld_b),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
      .rd_count(rdc_b), .wr_count(wrc_b), .wp_err(wpe_b), .wp_err_addr(wpa_b));

   fc8_bus_mem #(.RD_LAT(2), .CNT_W(4)) u_c (
      .clk(clk), .rst_n(rst_n), .mem_addr_in(addr), .mem_wdata_in(wdata),
      .mem_rd_en(rd_en), .mem_wr_en(wr_en), .mem_rdata_out(rdata_c), .rd_valid(vld_c),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
      .rd_count(rdc_c), .wr_count(wrc_c), .wp_err(wpe_c), .wp_err_addr(wpa_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a);
      rd_en = 1'b1; addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      wr_en = 1'b1; addr = a; wdata = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; wdata = '0; rd_en = 1'b0; wr_en = 1'b0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      tick(); tick();
      check("rst_rdata", 32'(rdata_a), 32'h0);
      check("rst_valid", 32'(vld_a), 32'h0);
      check("rst_rdcnt", 32'(rdc_a), 32'h0);
      check("rst_wrcnt", 32'(wrc_a), 32'h0);
      check("rst_wperr", 32'(wpe_a), 32'h0);
      check("rst_wpaddr", 32'(wpa_a), 32'h0);
      rst_n = 1'b1;
      tick();

      preload(16'h8000, 8'hEA);
      preload(16'h0010, 8'h11);
      preload(16'h0011, 8'h22);
      preload(16'h0012, 8'h33);
      preload(16'h0200, 8'hAA);
      preload(16'hFFFC, 8'h34);
      preload(16'h0100, 8'h5A);

      // RD_LAT=1: data one edge after the sampling edge, then held
      bus_read(16'h8000);
      check("lat1_valid", 32'(vld_a), 32'h1);
      check("lat1_data", 32'(rdata_a), 32'hEA);
      check("lat1_rdcnt", 32'(rdc_a), 32'h1);
      check("lat3_early", 32'(vld_b), 32'h0);
      tick();
      check("lat1_vld_drop", 32'(vld_a), 32'h0);
      check("lat1_hold", 32'(rdata_a), 32'hEA);
      tick(); tick();

      // RD_LAT=3: back-to-back reads
      rd_en = 1'b1; addr = 16'h0010; tick();
      addr = 16'h0011; tick();
      check("lat3_not_yet", 32'(vld_b), 32'h0);
      addr = 16'h0012; tick();
      rd_en = 1'b0;
      check("lat3_v0", 32'(vld_b), 32'h1);
      check("lat3_d0", 32'(rdata_b), 32'h11);
      tick();
      check("lat3_d1", {23'h0, vld_b, rdata_b}, {23'h0, 1'b1, 8'h22});
      tick();
      check("lat3_d2", {23'h0, vld_b, rdata_b}, {23'h0, 1'b1, 8'h33});
      tick();
      check("lat3_end", {23'h0, vld_b, rdata_b}, {23'h0, 1'b0, 8'h33});

      // Simultaneous read and write to the same address returns old data
      rd_en = 1'b1; wr_en = 1'b1; addr = 16'h0200; wdata = 8'h55;
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
      check("rw_old", 32'(rdata_a), 32'hAA);
      check("rw_wrcnt", 32'(wrc_a), 32'h1);
      bus_read(16'h0200);
      check("rw_new", 32'(rdata_a), 32'h55);

      // Write into the protected window
      bus_write(16'hFFFC, 8'h00);
`ifdef FC8_MEM_WP_EN
      check("wp_err", 32'(wpe_a), 32'h1);
      check("wp_addr", 32'(wpa_a), 32'hFFFC);
      check("wp_wrcnt", 32'(wrc_a), 32'h1);
      tick();
      check("wp_err_pulse", 32'(wpe_a), 32'h0);
      bus_read(16'hFFFC);
      check("wp_mem", 32'(rdata_a), 32'h34);
`else
      check("nowp_err", 32'(wpe_a), 32'h0);
      check("nowp_addr", 32'(wpa_a), 32'h0);
      check("nowp_wrcnt", 32'(wrc_a), 32'h2);
      bus_read(16'hFFFC);
      check("nowp_mem", 32'(rdata_a), 32'h00);
`endif
      preload(16'hFFFC, 8'h77);
      bus_read(16'hFFFC);
      check("wp_bd_write", 32'(rdata_a), 32'h77);

      // Bus write beats backdoor write to the same address; different addresses both land
      wr_en = 1'b1; addr = 16'h0300; wdata = 8'h66;
      bd_we = 1'b1; bd_addr = 16'h0300; bd_data = 8'h99;
      tick();
      addr = 16'h0302; wdata = 8'h44; bd_addr = 16'h0303; bd_data = 8'h45;
      tick();
      wr_en = 1'b0; bd_we = 1'b0;
      bus_read(16'h0300);
      check("bd_bus_same", 32'(rdata_a), 32'h66);
      bus_read(16'h0302);
      check("bd_bus_diff_bus", 32'(rdata_a), 32'h44);
      bus_read(16'h0303);
      check("bd_bus_diff_bd", 32'(rdata_a), 32'h45);

      // Saturating read counter on a 4-bit instance
      do_reset();
      for (int i = 0; i < 20; i++) begin
         rd_en = 1'b1; addr = 16'h0010; tick();
      end
      rd_en = 1'b0;
      check("sat_rdcnt_c", 32'(rdc_c), 32'hF);
      check("rdcnt_a_20", 32'(rdc_a), 32'd20);
      tick(); tick();
      check("sat_data_c", 32'(rdata_c), 32'h11);

      // Reset one cycle after a read on the RD_LAT=2 instance
      bus_read(16'h0100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(vld_c), 32'h0);
      check("mid_rst_data", 32'(rdata_c), 32'h0);
      check("mid_rst_rdcnt", 32'(rdc_c), 32'h0);
      tick();
      check("mid_rst_hold", 32'(vld_c), 32'h0);
      rst_n = 1'b1;
      tick();
      check("mid_rst_post1", 32'(vld_c), 32'h0);
      tick();
      check("mid_rst_post2", 32'(vld_c), 32'h0);
      bus_read(16'h0100);
      check("mid_rd_lat_early", 32'(vld_c), 32'h0);
      tick();
      check("mid_rd_valid", 32'(vld_c), 32'h1);
      check("mid_rd_data", 32'(rdata_c), 32'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fc8_bus_mem.md
# fc8_bus_mem

Parametrised, synthesizable memory responder for the fc8 CPU bus. It replaces the ad-hoc behavioural memory array in CPU benches and serves as the FPGA prototype RAM/ROM. The block generalises the fixed one-cycle, 64 KiB, 8-bit model:
- configurable address width, data width and read latency
- aligned read-valid strobe
- backdoor preload port
- saturating access counters
- optional write-protected window for ROM and vector space

## Interface
Parameters:
- ADDR_W, 16, address bits; depth = 2**ADDR_W words
- DATA_W, 8, word width
- RD_LAT, 1, read latency in cycles, legal range 1..4
- CNT_W, 16, access counter width
- WP_BASE, 16'hF000, first protected address (used only with FC8_MEM_WP_EN)
- WP_LIMIT, 16'hFFFF, last protected address, inclusive

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr_in  in  16  CPU address; bits above ADDR_W ignored (aliasing wrap)
- mem_wdata_in  in  DATA_W  CPU write data
- mem_rd_en  in  1  read request, sampled each edge
- mem_wr_en  in  1  write request, sampled each edge
- mem_rdata_out  out  DATA_W  read data
- rd_valid  out  1  high for one cycle when mem_rdata_out carries a new read result
- bd_we  in  1  backdoor write strobe (bench/loader)
- bd_addr  in  ADDR_W  backdoor address
- bd_data  in  DATA_W  backdoor data
- rd_count  out  CNT_W  accepted reads, saturating
- wr_count  out  CNT_W  committed bus writes, saturating
- wp_err  out  1  one-cycle pulse on a blocked write
- wp_err_addr  out  ADDR_W  address of most recent blocked write, sticky

## Operation
- Storage array is not reset; its contents persist across rst_n.
- Read: when mem_rd_en=1 at edge N, the array word is captured into pipeline stage 1. The value is the pre-write content if a write hits the same address at edge N.
  - The pipeline shifts each cycle.
  - At stage RD_LAT, mem_rdata_out is loaded and rd_valid is pulsed.
  - Back-to-back reads are accepted every cycle.
  - mem_rdata_out holds its last value between reads.
- Write: when mem_wr_en=1 at edge N, the array word is updated at edge N, unless blocked by write protect.
- Simultaneous rd_en and wr_en, any addresses: both are accepted. The read returns old data.
- Backdoor: bd_we writes at the edge, ignores protection and does not touch the counters.
  - Bus write and backdoor write to the same address in the same cycle: the bus write wins.
  - Different addresses: both land.
- Counters:
  - rd_count +1 per accepted read.
  - wr_count +1 per committed (unblocked) bus write.
  - Both hold at 2**CNT_W-1.
- Reset mid-read: in-flight pipeline stages are discarded. No rd_valid follows reset.

## Timing
- Reset values:
  - mem_rdata_out=0, rd_valid=0, rd_count=0, wr_count=0, wp_err=0, wp_err_addr=0
  - pipeline valid bits = 0
- Read latency is exactly RD_LAT edges from the sampling edge to rd_valid high. With RD_LAT=1, data is visible the cycle after rd_en, matching current CPU expectations.
- wp_err is asserted the cycle after the blocked write's edge, for one cycle only. wp_err_addr updates on the same edge.
- No backpressure; the block is always ready.

## Configuration
- FC8_MEM_WP_EN defined:
  - Bus writes with WP_BASE <= address <= WP_LIMIT, compared on the ADDR_W-truncated address, are dropped.
  - Such writes raise wp_err, update wp_err_addr and do not increment wr_count.
- Not defined:
  - All bus writes commit.
  - wp_err is tied 0; wp_err_addr is tied 0.
  - WP_BASE and WP_LIMIT are unused.

## Test plan
- RD_LAT=1:
  - Backdoor 8'hEA at 16'h8000; read 16'h8000 at edge N.
  - Expect rd_valid=1 and mem_rdata_out=8'hEA one cycle later, then rd_count=1.
- RD_LAT=3:
  - Read 16'h0010, 16'h0011 and 16'h0012 (preloaded 8'h11/8'h22/8'h33) on consecutive edges.
  - Expect rd_valid on 3 consecutive cycles starting 3 edges after the first read, with data in order.
- Simultaneous read and write:
  - Read and write 8'h55 to 16'h0200 (old 8'hAA) on the same edge.
  - Read returns 8'hAA; a subsequent read returns 8'h55; wr_count=1.
- FC8_MEM_WP_EN, defaults:
  - Bus write 8'h00 to 16'hFFFC (preloaded 8'h34).
  - Expect wp_err pulse, wp_err_addr=16'hFFFC, memory still 8'h34, wr_count=0.
  - Backdoor write to 16'hFFFC then succeeds.
- CNT_W=4:
  - Issue 20 reads.
  - Expect rd_count=4'hF, with no wrap.
- Reset mid-read:
  - RD_LAT=2; assert rst_n=0 one cycle after a read.
  - Expect no rd_valid, all outputs at reset values, and array contents intact on a later read.
